// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, line type and FSM states for the data cache
package dcache_pkg;

    localparam int DC_NUM_LINES = 32;
    localparam int DC_LINE_BITS = 256;
    localparam int DC_ADDR_W    = 32;
    localparam int WORD_W       = 32;

    localparam int OFFSET_W = $clog2(DC_LINE_BITS / WORD_W);
    localparam int INDEX_W  = $clog2(DC_NUM_LINES);
    localparam int TAG_W    = DC_ADDR_W - INDEX_W - OFFSET_W - 2;

    typedef logic [DC_LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        RESUME    = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - CPU-side and memory-side signal bundle of the data cache
interface dcache_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 256
);
    logic                 req_i;
    logic                 we_i;
    logic [ADDR_W-1:0]    addr_i;
    logic [31:0]          wdata_i;
    logic [31:0]          rdata_o;
    logic                 stall_o;
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_BITS-1:0] mem_wdata_o;
    logic                 mem_ack_i;
    logic [LINE_BITS-1:0] mem_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - valid/dirty/tag/data arrays with combinational read and one write port
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int LINE_BITS = DC_LINE_BITS,
    parameter int IDX_W     = INDEX_W,
    parameter int OFF_W     = OFFSET_W,
    parameter int TG_W      = TAG_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic                 o_rd_valid,
    output logic                 o_rd_dirty,
    output logic [TG_W-1:0]      o_rd_tag,
    output logic [LINE_BITS-1:0] o_rd_data,
    input  logic                 i_wr_line,
    input  logic                 i_wr_word,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [TG_W-1:0]      i_wr_tag,
    input  logic [LINE_BITS-1:0] i_wr_data,
    input  logic [OFF_W-1:0]     i_wr_off,
    input  logic [31:0]          i_wr_wdata
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TG_W-1:0]      r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_line) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= 1'b0;
        end else if (i_wr_word) begin
            r_dirty[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data are deliberately not reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (rst_i && i_wr_line) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end else if (rst_i && i_wr_word) begin
            r_data[i_wr_idx][{i_wr_off, 5'b0} +: 32] <= i_wr_wdata;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back cache controller; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = DC_NUM_LINES,
    parameter int LINE_BITS = DC_LINE_BITS,
    parameter int ADDR_W    = DC_ADDR_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int OFF_W = $clog2(LINE_BITS / WORD_W);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int LO    = OFF_W + 2;
    localparam int TG_W  = ADDR_W - IDX_W - LO;

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0]     w_idx;
    logic [TG_W-1:0]      w_tag;
    logic [OFF_W-1:0]     w_off;
    logic                 w_unused_addr;
    logic                 w_valid;
    logic                 w_dirty;
    logic [TG_W-1:0]      w_rd_tag;
    logic [LINE_BITS-1:0] w_rd_data;
    logic                 w_hit;
    logic                 w_wr_line;
    logic                 w_wr_word;
    logic                 w_stall;
    logic                 w_mem_req;
    logic                 w_mem_we;
    logic [ADDR_W-1:0]    w_mem_addr;
    logic [LINE_BITS-1:0] w_mem_wdata;

    assign w_idx         = bus.addr_i[LO +: IDX_W];
    assign w_tag         = bus.addr_i[ADDR_W-1 -: TG_W];
    assign w_off         = bus.addr_i[2 +: OFF_W];
    assign w_unused_addr = ^bus.addr_i[1:0];

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS),
        .IDX_W     (IDX_W),
        .OFF_W     (OFF_W),
        .TG_W      (TG_W)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_valid),
        .o_rd_dirty (w_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_line  (w_wr_line),
        .i_wr_word  (w_wr_word),
        .i_wr_idx   (w_idx),
        .i_wr_tag   (w_tag),
        .i_wr_data  (bus.mem_rdata_i),
        .i_wr_off   (w_off),
        .i_wr_wdata (bus.wdata_i)
    );

    assign w_hit = w_valid && (w_rd_tag == w_tag);

    // Invalid lines read as zero so uninitialised data never leaks out after reset.
    assign bus.rdata_o = w_valid ? w_rd_data[{w_off, 5'b0} +: WORD_W] : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_wr_line   = 1'b0;
        w_wr_word   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_i) begin
                    if (w_hit) begin
                        w_wr_word = bus.we_i;
                    end else begin
                        w_stall = 1'b1;
                        w_next  = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                w_stall     = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = {w_rd_tag, w_idx, {LO{1'b0}}};
                w_mem_wdata = w_rd_data;
                if (bus.mem_ack_i) begin
                    w_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                w_stall    = 1'b1;
                w_mem_req  = 1'b1;
                w_mem_addr = {w_tag, w_idx, {LO{1'b0}}};
                if (bus.mem_ack_i) begin
                    w_wr_line = 1'b1;
                    w_next    = RESUME;
                end
            end
            RESUME: begin
                w_stall = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.stall_o     = w_stall;
    assign bus.mem_req_o   = w_mem_req;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;

`ifdef DCACHE_STATS_EN
    logic        r_after_resume;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // The hit that completes a miss is not a fresh hit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_after_resume <= 1'b0;
            r_hit_cnt      <= '0;
            r_miss_cnt     <= '0;
        end else begin
            r_after_resume <= (r_state == RESUME);
            if (r_state == IDLE && bus.req_i && w_hit && !r_after_resume) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (r_state == IDLE && bus.req_i && !w_hit) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl with a line-wide memory responder
module tb_dcache_ctrl;

    localparam int LAT = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_if #(.ADDR_W(32), .LINE_BITS(256)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_ctrl #(.NUM_LINES(32), .LINE_BITS(256), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_stall;
    int ph_cnt;
    logic [31:0]  ph_addr  [8];
    logic         ph_we    [8];
    logic [255:0] ph_wdata [8];
    logic [31:0]  got_rdata;
    logic [255:0] mem [logic [31:0]];

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem.exists(a)) return mem[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {16'hA5A5, a[15:0]} + 32'(w);
        return l;
    endfunction

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
        int  cyc;
        bit  prev_req, prev_ack, done;
        bus.req_i = 1'b1; bus.we_i = w; bus.addr_i = a; bus.wdata_i = d;
        n_stall = 0; ph_cnt = 0; cyc = 0; prev_req = 0; prev_ack = 0; done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (!bus.stall_o) begin
                got_rdata = bus.rdata_o;
                done = 1;
            end else begin
                n_stall++;
                if (bus.mem_req_o) begin
                    if ((!prev_req || prev_ack) && ph_cnt < 8) begin
                        ph_addr[ph_cnt] = bus.mem_addr_o;
                        ph_we[ph_cnt] = bus.mem_we_o;
                        ph_wdata[ph_cnt] = bus.mem_wdata_o;
                        ph_cnt++;
                        cyc = 0;
                    end
                    cyc++;
                    prev_ack = 0;
                    if (cyc == LAT) begin
                        bus.mem_ack_i = 1'b1;
                        bus.mem_rdata_i = mem_line(bus.mem_addr_o);
                        if (bus.mem_we_o) mem[bus.mem_addr_o] = bus.mem_wdata_o;
                        prev_ack = 1;
                    end
                end else begin
                    prev_ack = 0;
                end
                prev_req = bus.mem_req_o;
                @(posedge clk); #1;
                bus.mem_ack_i = 1'b0;
            end
        end
        n_cmp++;
        if (!done) begin n_fail++; $display("FAIL access_timeout addr=%h: stall never released", a); end
        @(posedge clk); #1;
        bus.req_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", bus.stall_o); end
        n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req_o); end
        n_cmp++; if (bus.mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we_o); end
        n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr_o); end
        n_cmp++; if (bus.mem_wdata_o !== 256'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h want 0", bus.mem_wdata_o); end
        n_cmp++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus.rdata_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef DCACHE_STATS_EN
        n_cmp++; if (hit_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_hit_cnt got %0d want 0", hit_cnt); end
        n_cmp++; if (miss_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_miss_cnt got %0d want 0", miss_cnt); end
`endif
    endtask

    task automatic test_cold_load();
        access(1'b0, 32'h0000_0400, 32'h0);
        n_cmp++; if (ph_cnt !== 1) begin n_fail++; $display("FAIL cold_phases got %0d want 1", ph_cnt); end
        n_cmp++; if (ph_addr[0] !== 32'h400) begin n_fail++; $display("FAIL cold_addr got %h want 400", ph_addr[0]); end
        n_cmp++; if (ph_we[0] !== 1'b0) begin n_fail++; $display("FAIL cold_we got %b want 0", ph_we[0]); end
        n_cmp++; if (n_stall !== 11) begin n_fail++; $display("FAIL cold_stalls got %0d want 11", n_stall); end
        n_cmp++; if (got_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL cold_rdata got %h want 12345678", got_rdata); end
    endtask

    task automatic test_store_hit_load();
        access(1'b1, 32'h0000_0404, 32'hDEAD_BEEF);
        n_cmp++; if (n_stall !== 0) begin n_fail++; $display("FAIL sthit_stalls got %0d want 0", n_stall); end
        n_cmp++; if (ph_cnt !== 0) begin n_fail++; $display("FAIL sthit_phases got %0d want 0", ph_cnt); end
        access(1'b0, 32'h0000_0404, 32'h0);
        n_cmp++; if (n_stall !== 0) begin n_fail++; $display("FAIL ldhit_stalls got %0d want 0", n_stall); end
        n_cmp++; if (got_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ldhit_rdata got %h want deadbeef", got_rdata); end
    endtask

    task automatic test_dirty_evict();
        access(1'b0, 32'h0000_0804, 32'h0);
        n_cmp++; if (ph_cnt !== 2) begin n_fail++; $display("FAIL evict_phases got %0d want 2", ph_cnt); end
        n_cmp++; if (ph_addr[0] !== 32'h400 || ph_we[0] !== 1'b1) begin n_fail++; $display("FAIL evict_wb got addr %h we %b want 400/1", ph_addr[0], ph_we[0]); end
        n_cmp++; if (ph_wdata[0][63:32] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL evict_wdata1 got %h want deadbeef", ph_wdata[0][63:32]); end
        n_cmp++; if (ph_wdata[0][31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL evict_wdata0 got %h want 12345678", ph_wdata[0][31:0]); end
        n_cmp++; if (ph_addr[1] !== 32'h800 || ph_we[1] !== 1'b0) begin n_fail++; $display("FAIL evict_alloc got addr %h we %b want 800/0", ph_addr[1], ph_we[1]); end
        n_cmp++; if (n_stall !== 20) begin n_fail++; $display("FAIL evict_stalls got %0d want 20", n_stall); end
        n_cmp++; if (got_rdata !== 32'hA5A5_0801) begin n_fail++; $display("FAIL evict_rdata got %h want a5a50801", got_rdata); end
        access(1'b0, 32'h0000_0404, 32'h0);
        n_cmp++; if (ph_cnt !== 1 || ph_we[0] !== 1'b0) begin n_fail++; $display("FAIL reload_phases got %0d we %b want 1/0", ph_cnt, ph_we[0]); end
        n_cmp++; if (n_stall !== 11) begin n_fail++; $display("FAIL reload_stalls got %0d want 11", n_stall); end
        n_cmp++; if (got_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reload_rdata got %h want deadbeef", got_rdata); end
    endtask

    task automatic test_store_miss();
        access(1'b1, 32'h0000_1010, 32'hCAFE_0001);
        n_cmp++; if (ph_cnt !== 1 || ph_addr[0] !== 32'h1000) begin n_fail++; $display("FAIL stmiss_phase got %0d addr %h want 1/1000", ph_cnt, ph_addr[0]); end
        n_cmp++; if (n_stall !== 11) begin n_fail++; $display("FAIL stmiss_stalls got %0d want 11", n_stall); end
        access(1'b0, 32'h0000_1010, 32'h0);
        n_cmp++; if (n_stall !== 0) begin n_fail++; $display("FAIL stmiss_ld_stalls got %0d want 0", n_stall); end
        n_cmp++; if (got_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL stmiss_ld_rdata got %h want cafe0001", got_rdata); end
    endtask

    task automatic test_stray_ack();
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = {256{1'b1}};
        @(negedge clk);
        n_cmp++; if (bus.mem_req_o !== 1'b0 || bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL stray_idle got req %b stall %b want 0/0", bus.mem_req_o, bus.stall_o); end
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        access(1'b0, 32'h0000_1010, 32'h0);
        n_cmp++; if (n_stall !== 0) begin n_fail++; $display("FAIL stray_stalls got %0d want 0", n_stall); end
        n_cmp++; if (got_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL stray_rdata got %h want cafe0001", got_rdata); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        n_cmp++; if (hit_cnt !== 32'd4) begin n_fail++; $display("FAIL stats_hits got %0d want 4", hit_cnt); end
        n_cmp++; if (miss_cnt !== 32'd4) begin n_fail++; $display("FAIL stats_misses got %0d want 4", miss_cnt); end
    endtask
`endif

    task automatic test_victim_writeback();
        access(1'b0, 32'h0000_0010, 32'h0);
        n_cmp++; if (ph_cnt !== 2) begin n_fail++; $display("FAIL victim_phases got %0d want 2", ph_cnt); end
        n_cmp++; if (ph_addr[0] !== 32'h1000 || ph_we[0] !== 1'b1) begin n_fail++; $display("FAIL victim_wb got addr %h we %b want 1000/1", ph_addr[0], ph_we[0]); end
        n_cmp++; if (ph_wdata[0][159:128] !== 32'hCAFE_0001) begin n_fail++; $display("FAIL victim_wdata4 got %h want cafe0001", ph_wdata[0][159:128]); end
        n_cmp++; if (ph_addr[1] !== 32'h0) begin n_fail++; $display("FAIL victim_alloc got %h want 0", ph_addr[1]); end
        n_cmp++; if (n_stall !== 20) begin n_fail++; $display("FAIL victim_stalls got %0d want 20", n_stall); end
        n_cmp++; if (got_rdata !== 32'hA5A5_0004) begin n_fail++; $display("FAIL victim_rdata got %h want a5a50004", got_rdata); end
    endtask

    task automatic test_reset_mid_refill();
        bit found;
        found = 0;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h0000_2000; bus.wdata_i = 32'h0;
        for (int t = 0; t < 10 && !found; t++) begin
            @(negedge clk);
            if (bus.mem_req_o && !bus.mem_we_o) found = 1;
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL midrst_alloc got no ALLOCATE request want one"); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL midrst_req got %b want 0", bus.mem_req_o); end
        n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL midrst_addr got %h want 0", bus.mem_addr_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1'b0, 32'h0000_2000, 32'h0);
        n_cmp++; if (ph_cnt !== 1 || ph_addr[0] !== 32'h2000) begin n_fail++; $display("FAIL midrst_rerun got %0d addr %h want 1/2000", ph_cnt, ph_addr[0]); end
        n_cmp++; if (n_stall !== 11) begin n_fail++; $display("FAIL midrst_stalls got %0d want 11", n_stall); end
        n_cmp++; if (got_rdata !== 32'hA5A5_2000) begin n_fail++; $display("FAIL midrst_rdata got %h want a5a52000", got_rdata); end
    endtask

    initial begin
        logic [255:0] l;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        l = mem_line(32'h400);
        l[31:0] = 32'h1234_5678;
        mem[32'h400] = l;
        test_reset();
        test_cold_load();
        test_store_hit_load();
        test_dirty_evict();
        test_store_miss();
        test_stray_ack();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_victim_writeback();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end

endmodule
